// File: rtl/riscv_pkg.sv
// Shared core types and constants.
// Fetch adds its FSM state and the fetch->decode entry bundle.
package riscv_pkg;

    localparam int FETCH_PC_WIDTH    = 32;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int INSTRUCTION_BYTES = 4;

    typedef enum logic {
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_PC_WIDTH-1:0]    pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instruction} entries.
// Flush empties it in one edge; push and pop may coincide when full.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    fetch_entry_t  mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, redirect/fault FSM and ROM capture buffer.
// Entries reach decode one cycle after fetch; redirects flush the buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int               XLEN         = FETCH_PC_WIDTH,
    parameter logic [XLEN-1:0]  RESET_PC     = '0,
    parameter int               BUFFER_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [XLEN-1:0]              imem_address,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_instruction,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [XLEN-1:0]              out_pc,
    output logic                         fetch_fault
);

    localparam int CW = $clog2(BUFFER_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            redirect_aligned;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    assign imem_address = fetch_pc;
    assign fetch_fault  = (state == FETCH_FAULT);

    // A redirect hides the stale head so no handshake happens.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = (state == FETCH_RUN) && !redirect_valid
                     && (!full || pop);

    assign wr_entry.pc          = fetch_pc;
    assign wr_entry.instruction = imem_instruction;

    assign out_instruction = empty ? '0 : head.instruction;
    assign out_pc          = empty ? '0 : head.pc;

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = redirect_aligned ? FETCH_RUN : FETCH_FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + XLEN'(INSTRUCTION_BYTES);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, wrap and async-reset
// sequences, then random redirects/backpressure against a queue model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        fetch_fault;

    logic [31:0] w_address;
    logic [31:0] w_instruction;
    logic        w_rv = 1'b0;
    logic [31:0] w_rp = '0;
    logic        w_valid;
    logic        w_ready = 1'b1;
    logic [31:0] w_out_instruction;
    logic [31:0] w_out_pc;
    logic        w_fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0000_0013 + (a >> 2);
    endfunction

    assign imem_instruction = rom(imem_address);
    assign w_instruction    = rom(w_address);

    fetch_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .fetch_fault      (fetch_fault)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_address     (w_address),
        .imem_instruction (w_instruction),
        .redirect_valid   (w_rv),
        .redirect_pc      (w_rp),
        .out_valid        (w_valid),
        .out_ready        (w_ready),
        .out_instruction  (w_out_instruction),
        .out_pc           (w_out_pc),
        .fetch_fault      (w_fault)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] rp;
        bit          rdy;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] ea;
        bit          ef;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] mq[$];
    logic [31:0] mpc;
    bit          mf;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          rv;
        logic [31:0] rp;
        bit          rdy;
        bit          ev;

        tbl.push_back('{0, 32'h0,   1, 0, 32'h0,   32'h0,   0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h0,   32'h4,   0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h4,   32'h8,   0});
        tbl.push_back('{0, 32'h0,   0, 1, 32'h8,   32'hC,   0});
        tbl.push_back('{0, 32'h0,   0, 1, 32'h8,   32'h10,  0});
        tbl.push_back('{0, 32'h0,   0, 1, 32'h8,   32'h10,  0});
        tbl.push_back('{0, 32'h0,   0, 1, 32'h8,   32'h10,  0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h8,   32'h10,  0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'hC,   32'h14,  0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h10,  32'h18,  0});
        tbl.push_back('{1, 32'h100, 1, 0, 32'h0,   32'h1C,  0});
        tbl.push_back('{0, 32'h0,   1, 0, 32'h0,   32'h100, 0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h100, 32'h104, 0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h104, 32'h108, 0});
        tbl.push_back('{1, 32'h102, 1, 0, 32'h0,   32'h10C, 0});
        tbl.push_back('{0, 32'h0,   1, 0, 32'h0,   32'h100, 1});
        tbl.push_back('{0, 32'h0,   1, 0, 32'h0,   32'h100, 1});
        tbl.push_back('{1, 32'h200, 1, 0, 32'h0,   32'h100, 1});
        tbl.push_back('{0, 32'h0,   1, 0, 32'h0,   32'h200, 0});
        tbl.push_back('{0, 32'h0,   1, 1, 32'h200, 32'h204, 0});
        tbl.push_back('{0, 32'h0,   0, 1, 32'h204, 32'h208, 0});
        tbl.push_back('{0, 32'h0,   0, 1, 32'h204, 32'h20C, 0});

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'h0);
        chk("rst_addr", imem_address, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instruction, 32'h0);
        chk("rst_w_addr", w_address, 32'hFFFF_FFF8);

        next_cycle();
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            if (i > 0) next_cycle();
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rp;
            out_ready      = tbl[i].rdy;
            #2;
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("t%0d_addr", i), imem_address, tbl[i].ea);
            chk($sformatf("t%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].ef));
            if (tbl[i].ev) begin
                chk($sformatf("t%0d_pc", i), out_pc, tbl[i].epc);
                chk($sformatf("t%0d_instr", i), out_instruction,
                    rom(tbl[i].epc));
            end
            if (i >= 1 && i <= 3) begin
                chk($sformatf("wrap%0d_valid", i), 32'(w_valid), 32'h1);
                chk($sformatf("wrap%0d_pc", i), w_out_pc,
                    32'hFFFF_FFF8 + 32'(4 * (i - 1)));
            end
        end

        // Async reset with a full buffer, mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_addr", imem_address, 32'h0);
        chk("arst_fault", 32'(fetch_fault), 32'h0);

        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        mq.delete();
        mpc = '0;
        mf  = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i > 0) next_cycle();
            if (i < 2) begin
                rv  = 1'b0;
                rdy = 1'b1;
                rp  = '0;
            end else begin
                rv  = ($urandom_range(0, 7) == 0);
                rdy = ($urandom_range(0, 9) < 7);
                rp  = {20'h0, 10'($urandom), 2'b00};
                if ($urandom_range(0, 3) == 0)
                    rp[1:0] = 2'($urandom_range(1, 3));
            end
            redirect_valid = rv;
            redirect_pc    = rp;
            out_ready      = rdy;
            #2;
            ev = (mq.size() != 0) && !rv;
            chk("rnd_valid", 32'(out_valid), 32'(ev));
            chk("rnd_addr", imem_address, mpc);
            chk("rnd_fault", 32'(fetch_fault), 32'(mf));
            if (mq.size() != 0) begin
                chk("rnd_pc", out_pc, mq[0]);
                chk("rnd_instr", out_instruction, rom(mq[0]));
            end else begin
                chk("rnd_pc_empty", out_pc, 32'h0);
            end
            if (rv) begin
                mq.delete();
                mpc = rp & 32'hFFFF_FFFC;
                mf  = (rp[1:0] != 2'b00);
            end else begin
                if (ev && rdy) void'(mq.pop_front());
                if (!mf && mq.size() < 2) begin
                    mq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end

        // Async reset clears a fault while a redirect is pending
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7;
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        chk("pre_fault", 32'(fetch_fault), 32'h1);
        chk("pre_addr", imem_address, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst2_fault", 32'(fetch_fault), 32'h0);
        chk("arst2_valid", 32'(out_valid), 32'h0);
        chk("arst2_addr", imem_address, 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        rst_n = 1'b1;
        next_cycle();
        #2;
        chk("restart_valid", 32'(out_valid), 32'h1);
        chk("restart_pc", out_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
